// File: rtl/spi_mem_engine.sv
// spi_mem_engine
//   Serial memory engine that turns a single-word bus request into one SPI
//   mode-0 frame to either an SPI SRAM or an SPI Flash. A frame is the
//   command byte (0x03 read / 0x02 write), the address, then 16 data bits
//   sent little-endian by byte, each byte MSB first. Flash writes are not
//   supported on the wire and complete immediately without touching the bus.
//
// Parameters
//   SCLK_DIV       : SCLK half-period in clk cycles (0 is treated as 1)
//   RAM_ADDR_BYTES : number of address bytes sent to the SRAM
//
// Ports
//   clk            : system clock, rising edge
//   reset          : synchronous active-low reset
//   req            : transaction request (edge-armed, see 'armed')
//   we             : 1 = write, 0 = read
//   addr           : CPU byte address
//   wdata          : write word
//   cs_select      : 0 = SRAM, 1 = Flash
//   rdata          : last read word (held across writes)
//   ready          : one-cycle completion pulse
//   busy           : transaction in progress
//   spi_sclk       : SPI clock, idle low
//   spi_mosi       : serial data out
//   spi_miso       : serial data in
//   spi_ram_cs_n   : SRAM chip select, active low
//   spi_flash_cs_n : Flash chip select, active low
module spi_mem_engine #(
    parameter int SCLK_DIV       = 1,
    parameter int RAM_ADDR_BYTES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [15:0] addr,
    input  logic [15:0] wdata,
    input  logic        cs_select,
    output logic [15:0] rdata,
    output logic        ready,
    output logic        busy,
    output logic        spi_sclk,
    output logic        spi_mosi,
    input  logic        spi_miso,
    output logic        spi_ram_cs_n,
    output logic        spi_flash_cs_n
);

    localparam int DIV     = (SCLK_DIV < 1) ? 1 : SCLK_DIV;
    localparam int RAB     = (RAM_ADDR_BYTES < 1) ? 1 : RAM_ADDR_BYTES;
    localparam int RAW     = 8 * RAB;
    localparam int N_RAM   = 24 + RAW;
    localparam int N_FLASH = 48;
    // Frame register is sized for the longer of the two frame formats and
    // holds the frame left-aligned so the next bit is always the MSB.
    localparam int FW      = (N_RAM > N_FLASH) ? N_RAM : N_FLASH;
    localparam int CW      = $clog2(FW + 1);
    localparam int DW      = (DIV < 2) ? 1 : $clog2(DIV);

    typedef enum logic [1:0] {IDLE, SHIFT, HOLD, DONE} state_t;

    state_t          state;
    logic            armed;
    logic            we_q;
    logic [FW-1:0]   tx;
    logic [15:0]     rx;
    logic [DW-1:0]   div_cnt;
    logic [CW-1:0]   bit_cnt;
    logic [CW-1:0]   n_bits;

    logic [FW-1:0]   frame_next;
    logic [7:0]      cmd;
    logic [15:0]     data_le;
    logic [RAW-1:0]  ram_addr;

    // Frame assembled straight from the request inputs; only used on the
    // acceptance edge, after which the shift register owns the bits.
    always_comb begin
        cmd      = we ? 8'h02 : 8'h03;
        data_le  = we ? {wdata[7:0], wdata[15:8]} : 16'h0000;
        ram_addr = RAW'(addr);
        if (cs_select)
            frame_next = FW'({cmd, 12'h000, addr[11:0], data_le}) << (FW - N_FLASH);
        else
            frame_next = FW'({cmd, ram_addr, data_le}) << (FW - N_RAM);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state          <= IDLE;
            armed          <= 1'b1;
            we_q           <= 1'b0;
            busy           <= 1'b0;
            ready          <= 1'b0;
            rdata          <= 16'h0000;
            spi_sclk       <= 1'b0;
            spi_mosi       <= 1'b0;
            spi_ram_cs_n   <= 1'b1;
            spi_flash_cs_n <= 1'b1;
            tx             <= '0;
            rx             <= 16'h0000;
            div_cnt        <= '0;
            bit_cnt        <= '0;
            n_bits         <= '0;
        end else begin
            ready <= 1'b0;
            case (state)
                IDLE: begin
                    // A request must be seen low before another is taken,
                    // so a req held past ready cannot start a second frame.
                    if (!req)
                        armed <= 1'b1;
                    if (req && armed) begin
                        armed <= 1'b0;
                        busy  <= 1'b1;
                        we_q  <= we;
                        if (we && cs_select) begin
                            state <= DONE;
                        end else begin
                            state          <= SHIFT;
                            spi_mosi       <= frame_next[FW-1];
                            tx             <= frame_next << 1;
                            spi_ram_cs_n   <= cs_select;
                            spi_flash_cs_n <= !cs_select;
                            n_bits         <= cs_select ? CW'(N_FLASH) : CW'(N_RAM);
                            bit_cnt        <= '0;
                            div_cnt        <= '0;
                            spi_sclk       <= 1'b0;
                        end
                    end
                end
                SHIFT: begin
                    if (div_cnt == DW'(DIV - 1)) begin
                        div_cnt <= '0;
                        if (!spi_sclk) begin
                            // Rising edge: capture MISO on the same clk edge.
                            spi_sclk <= 1'b1;
                            rx       <= {rx[14:0], spi_miso};
                        end else begin
                            // Falling edge: the only place MOSI is updated.
                            spi_sclk <= 1'b0;
                            if (bit_cnt == n_bits - 1'b1) begin
                                state    <= HOLD;
                                spi_mosi <= 1'b0;
                            end else begin
                                bit_cnt  <= bit_cnt + 1'b1;
                                spi_mosi <= tx[FW-1];
                                tx       <= tx << 1;
                            end
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                HOLD: begin
                    state          <= DONE;
                    spi_ram_cs_n   <= 1'b1;
                    spi_flash_cs_n <= 1'b1;
                end
                DONE: begin
                    state <= IDLE;
                    ready <= 1'b1;
                    busy  <= 1'b0;
                    // First received data byte is the low byte of the word.
                    if (!we_q)
                        rdata <= {rx[7:0], rx[15:8]};
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_mem_engine.sv
// Testbench for spi_mem_engine: random and directed transactions, scoreboard
// queue of expected responses, SPI slave/monitor checking the wire frame.
module tb_spi_mem_engine;

    localparam int D     = 1;
    localparam int N_RAM = 40;
    localparam int N_FL  = 48;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [15:0] addr = 16'h0;
    logic [15:0] wdata = 16'h0;
    logic        cs_select = 1'b0;
    logic [15:0] rdata;
    logic        ready;
    logic        busy;
    logic        spi_sclk;
    logic        spi_mosi;
    logic        spi_miso = 1'b0;
    logic        spi_ram_cs_n;
    logic        spi_flash_cs_n;

    spi_mem_engine #(.SCLK_DIV(D), .RAM_ADDR_BYTES(2)) dut (
        .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr),
        .wdata(wdata), .cs_select(cs_select), .rdata(rdata), .ready(ready),
        .busy(busy), .spi_sclk(spi_sclk), .spi_mosi(spi_mosi),
        .spi_miso(spi_miso), .spi_ram_cs_n(spi_ram_cs_n),
        .spi_flash_cs_n(spi_flash_cs_n)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    typedef struct {
        logic [15:0] rdata;
        int          lat;
        int          nbits;
        int          ncheck;
        logic [47:0] bits;
        int          cs;      // 0 = SRAM, 1 = Flash, 2 = no bus activity
        int          t0;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad = 0;
    int          done_cnt = 0;
    logic [47:0] miso_frame = 48'h0;
    logic [15:0] model_rdata = 16'h0;

    task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // SPI slave + monitor: samples the bus away from the active edge.
    logic [47:0] cap = 48'h0;
    int          cap_n = 0;
    int          ram_falls = 0;
    int          fl_falls = 0;
    int          low_cyc = 0;
    logic        p_sclk = 1'b0, p_ram = 1'b1, p_fl = 1'b1;

    always @(negedge clk) begin
        if (!reset) begin
            cap = 48'h0; cap_n = 0; ram_falls = 0; fl_falls = 0; low_cyc = 0;
        end else begin
            if (spi_sclk && !p_sclk) begin
                if (cap_n < 48) cap[47 - cap_n] = spi_mosi;
                cap_n++;
            end
            if (!spi_ram_cs_n && p_ram) ram_falls++;
            if (!spi_flash_cs_n && p_fl) fl_falls++;
            if (!spi_ram_cs_n || !spi_flash_cs_n) low_cyc++;
            if (!spi_ram_cs_n && !spi_flash_cs_n)
                chk("cs_exclusive", 48'd0, 48'd1);
            if (ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_ready", 48'd1, 48'd0);
                end else begin
                    exp_t e;
                    logic [47:0] m;
                    e = sb.pop_front();
                    m = (e.ncheck == 0) ? 48'h0 : ({48{1'b1}} << (48 - e.ncheck));
                    chk("latency", 48'(cyc - e.t0), 48'(e.lat));
                    chk("rdata", 48'(rdata), 48'(e.rdata));
                    chk("sclk_bits", 48'(cap_n), 48'(e.nbits));
                    chk("mosi_frame", cap & m, e.bits & m);
                    chk("ram_cs_falls", 48'(ram_falls), (e.cs == 0) ? 48'd1 : 48'd0);
                    chk("flash_cs_falls", 48'(fl_falls), (e.cs == 1) ? 48'd1 : 48'd0);
                    chk("cs_low_cycles", 48'(low_cyc), (e.cs == 2) ? 48'd0 : 48'(2 * D * e.nbits + 1));
                end
                cap = 48'h0; cap_n = 0; ram_falls = 0; fl_falls = 0; low_cyc = 0;
                done_cnt++;
            end
        end
        spi_miso <= (cap_n < 48) ? miso_frame[47 - cap_n] : 1'b0;
        p_sclk = spi_sclk; p_ram = spi_ram_cs_n; p_fl = spi_flash_cs_n;
    end

    // Issue one request; push the expected response unless told not to.
    task automatic issue(input logic w, input logic cs, input logic [15:0] a,
                         input logic [15:0] wd, input logic [15:0] rd,
                         input bit push, input bit hold);
        exp_t e;
        int   n;
        logic [7:0] c;
        @(negedge clk);
        n = cs ? N_FL : N_RAM;
        c = w ? 8'h02 : 8'h03;
        miso_frame = 48'({rd[7:0], rd[15:8]}) << (48 - n);
        e.t0 = cyc + 1;
        if (w && cs) begin
            e.lat = 1; e.nbits = 0; e.ncheck = 0; e.bits = 48'h0; e.cs = 2;
        end else begin
            e.lat    = 2 + 2 * D * n;
            e.nbits  = n;
            e.cs     = cs ? 1 : 0;
            e.ncheck = w ? n : n - 16;
            if (cs) e.bits = {c, 8'h00, 4'h0, a[11:8], a[7:0], wd[7:0], wd[15:8]};
            else    e.bits = {c, a[15:8], a[7:0], wd[7:0], wd[15:8], 8'h00};
        end
        if (!w) model_rdata = rd;
        e.rdata = model_rdata;
        if (push) sb.push_back(e);
        we = w; cs_select = cs; addr = a; wdata = wd; req = 1'b1;
        @(negedge clk);
        if (!hold) req = 1'b0;
        // Inputs wiggle while busy; the engine must ignore them.
        we = 1'($urandom); cs_select = 1'($urandom);
        addr = 16'($urandom); wdata = 16'($urandom);
    endtask

    task automatic wait_done(input int start);
        int k;
        k = 0;
        while (done_cnt == start && k < 3000) begin
            @(negedge clk);
            k++;
        end
        if (done_cnt == start) chk("ready_timeout", 48'd0, 48'd1);
    endtask

    task automatic run(input logic w, input logic cs, input logic [15:0] a,
                       input logic [15:0] wd, input logic [15:0] rd);
        int s;
        s = done_cnt;
        issue(w, cs, a, wd, rd, 1'b1, 1'b0);
        wait_done(s);
    endtask

    initial begin
        int s, k;
        repeat (3) @(negedge clk);
        chk("rst_busy", 48'(busy), 48'd0);
        chk("rst_ready", 48'(ready), 48'd0);
        chk("rst_rdata", 48'(rdata), 48'd0);
        chk("rst_sclk", 48'(spi_sclk), 48'd0);
        chk("rst_mosi", 48'(spi_mosi), 48'd0);
        chk("rst_cs", 48'({spi_ram_cs_n, spi_flash_cs_n}), 48'd3);
        reset = 1'b1;
        @(negedge clk);

        run(1'b0, 1'b0, 16'h1234, 16'h0000, 16'hABCD);   // SRAM read
        chk("rdata_abcd", 48'(rdata), 48'hABCD);
        run(1'b1, 1'b0, 16'h0100, 16'hBEEF, 16'h5555);   // SRAM write
        chk("rdata_kept", 48'(rdata), 48'hABCD);
        run(1'b0, 1'b1, 16'hE345, 16'h0000, 16'h1357);   // Flash read
        run(1'b1, 1'b1, 16'hE000, 16'h4242, 16'h0000);   // Flash write
        chk("idle_cs", 48'({spi_ram_cs_n, spi_flash_cs_n}), 48'd3);
        run(1'b0, 1'b0, 16'hFFFF, 16'h0000, 16'h0F0F);   // no range check

        // req held across completion and beyond: only one transaction.
        s = done_cnt;
        issue(1'b0, 1'b0, 16'h2468, 16'h0, 16'h9876, 1'b1, 1'b1);
        wait_done(s);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("held_req_busy", 48'(busy), 48'd0);
        end
        req = 1'b0;
        @(negedge clk);
        run(1'b1, 1'b0, 16'h0042, 16'hCAFE, 16'h0);

        // Reset in the middle of an SRAM read: no ready, CS released.
        issue(1'b0, 1'b0, 16'h3333, 16'h0, 16'h7777, 1'b0, 1'b0);
        k = 0;
        while (cap_n < 20 && k < 500) begin
            @(negedge clk);
            k++;
        end
        chk("reached_bit20", 48'(cap_n >= 20), 48'd1);
        reset = 1'b0;
        model_rdata = 16'h0;
        @(negedge clk);
        chk("abort_cs", 48'({spi_ram_cs_n, spi_flash_cs_n}), 48'd3);
        chk("abort_busy", 48'(busy), 48'd0);
        chk("abort_ready", 48'(ready), 48'd0);
        chk("abort_rdata", 48'(rdata), 48'd0);
        @(negedge clk);
        reset = 1'b1;
        run(1'b0, 1'b0, 16'h3333, 16'h0, 16'h7777);

        for (int i = 0; i < 16; i++)
            run(1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));

        repeat (5) @(negedge clk);
        chk("scoreboard_empty", 48'(sb.size()), 48'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
